sent_rx_crc_chk: RTL

SENT_RX_CRC_CHK -- requirements
Module: sent_rx_crc_chk

---
 rtl/sent_rx_crc_chk.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sent_rx_crc_chk.sv
// SENT receive-side CRC checker: recomputes the CRC4/CRC6 of a captured frame bit-serially.
// Optional mismatch counter enabled by defining SENT_RX_CRC_ERR_CNT_EN.
module sent_rx_crc_chk (
  input  logic        clk_tx,
  input  logic        reset_n_tx,
  input  logic        start_i,
  input  logic [2:0]  mode_i,
  input  logic [23:0] data_i,
  input  logic [5:0]  crc_rx_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        crc_ok_o,
  output logic [5:0]  crc_calc_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StCmp, StDone} state_e;

  state_e      state_q;
  logic [2:0]  mode_q;
  logic [23:0] data_q;
  logic [5:0]  crc_rx_q;
  logic [5:0]  rem_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        ok_q;
  logic [5:0]  calc_q;

  logic        crc6;
  logic        start_legal;
  logic [4:0]  load_len;
  logic [4:0]  bit_idx;
  logic        in_bit;
  logic [5:0]  rem_nxt;
  logic        crc_match;

  assign crc6        = (mode_q == 3'b101);
  assign start_legal = start_i && (mode_i inside {[3'd1:3'd5]});

  always_comb begin
    load_len = 5'd16;
    unique case (mode_q)
      3'b001:  load_len = 5'd28;
      3'b010:  load_len = 5'd20;
      3'b101:  load_len = 5'd30;
      default: load_len = 5'd16;
    endcase
  end

  // Counter runs N+W..1: data bits while above W, augmentation zeros after.
  always_comb begin
    bit_idx = cnt_q - (crc6 ? 5'd7 : 5'd5);
    in_bit  = (cnt_q > (crc6 ? 5'd6 : 5'd4)) ? data_q[bit_idx] : 1'b0;
    if (crc6) begin
      rem_nxt = {rem_q[4:0], in_bit} ^ (rem_q[5] ? 6'h19 : 6'h00);
    end else begin
      rem_nxt = {2'b00, rem_q[2:0], in_bit} ^ (rem_q[3] ? 6'h0D : 6'h00);
    end
    crc_match = crc6 ? (rem_q == crc_rx_q) : (rem_q[3:0] == crc_rx_q[3:0]);
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      data_q   <= '0;
      crc_rx_q <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      calc_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_legal) begin
            mode_q   <= mode_i;
            data_q   <= data_i;
            crc_rx_q <= crc_rx_i;
            busy_q   <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          rem_q   <= crc6 ? 6'h15 : 6'h05;
          cnt_q   <= load_len;
          state_q <= StShift;
        end
        StShift: begin
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= StCmp;
        end
        StCmp: begin
          calc_q  <= rem_q;
          ok_q    <= crc_match;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign crc_ok_o   = ok_q;
  assign crc_calc_o = calc_q;

`ifdef SENT_RX_CRC_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      err_q <= '0;
    end else if ((state_q == StCmp) && !crc_match && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_cnt_o = err_q;
`else
  assign err_cnt_o = 8'h00;
`endif

endmodule
